// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: one outstanding memory read feeding a small
// in-order queue of {word, address} entries, flushable by redirects.

package CpuParams;
  parameter int ADDR_WIDTH = 32;
  parameter int WORD_SIZE  = 4;
  parameter int WORD_WIDTH = 32;
endpackage

module ifu_prefetch #(
  parameter int ADDR_WIDTH = CpuParams::ADDR_WIDTH,
  parameter int WORD_SIZE  = CpuParams::WORD_SIZE,
  parameter int WORD_WIDTH = CpuParams::WORD_WIDTH,
  parameter int DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    mem_read_request,
  output logic [ADDR_WIDTH-1:0]   mem_read_addr,
  input  logic                    mem_read_data_ready,
  input  logic [WORD_WIDTH-1:0]   mem_read_data,
  input  logic                    redirect_valid,
  input  logic [ADDR_WIDTH-1:0]   redirect_addr,
  output logic                    insn_valid,
  input  logic                    insn_ready,
  output logic [WORD_WIDTH-1:0]   insn_data,
  output logic [ADDR_WIDTH-1:0]   insn_addr,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         cnt_nxt;
  logic [PW-1:0]         rd_ptr_q;
  logic [PW-1:0]         wr_ptr_q;
  logic                  push;
  logic                  pop;
  logic                  room;
  logic                  start_req;

  logic [WORD_WIDTH-1:0] data_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];

  assign pc_inc = fetch_pc_q + ADDR_WIDTH'(WORD_SIZE);

  assign push = !reset && (state_q == REQ)
              && mem_read_data_ready && !redirect_valid;

  assign pop = !reset && (count_q != '0)
             && insn_ready && !redirect_valid;

  assign start_req = (state_q == IDLE) && (state_d == REQ);

  // Occupancy after this cycle's push/pop, used to decide on the next fetch
  always_comb begin
    cnt_nxt = count_q;
    if (push && !pop) cnt_nxt = count_q + CW'(1);
    if (pop && !push) cnt_nxt = count_q - CW'(1);
  end

  assign room = cnt_nxt < FULL;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: a redirect during a pending read waits it out in DROP
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!redirect_valid && (count_q < FULL))
          state_d = REQ;
      end
      REQ: begin
        if (redirect_valid)
          state_d = mem_read_data_ready ? IDLE : DROP;
        else if (mem_read_data_ready && !room)
          state_d = IDLE;
      end
      DROP: begin
        if (mem_read_data_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: reset forces the idle view without waiting for an edge
  always_comb begin
    mem_read_request = !reset && (state_q != IDLE);
    mem_read_addr    = reset ? RESET_PC : addr_q;
    count            = reset ? '0 : count_q;
    insn_valid       = !reset && (count_q != '0);
    insn_data        = '0;
    insn_addr        = '0;
    if (insn_valid) begin
      insn_data = data_mem[rd_ptr_q];
      insn_addr = addr_mem[rd_ptr_q];
    end
  end

  // Fetch PC and the address held on the memory port
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      if (redirect_valid)
        fetch_pc_q <= redirect_addr;
      else if (push)
        fetch_pc_q <= pc_inc;
      if (start_req)
        addr_q <= fetch_pc_q;
      else if (push && (state_d == REQ))
        addr_q <= pc_inc;
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q <= cnt_nxt;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Queue storage, valid only below the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= mem_read_data;
      addr_mem[wr_ptr_q] <= addr_q;
    end
  end

endmodule

// File: doc/ifu_prefetch.md
IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 Parameter ADDR_WIDTH, default CpuParams::ADDR_WIDTH, SHALL set the fetch address width.
REQ-002 Parameter WORD_SIZE, default CpuParams::WORD_SIZE, SHALL set the byte increment per fetched word.
REQ-003 Parameter WORD_WIDTH, default CpuParams::WORD_WIDTH, SHALL set the instruction word width.
REQ-004 Parameter DEPTH, default 4, SHALL set the prefetch queue depth (power of two, >=2).
REQ-005 Parameter RESET_PC, default 0, SHALL set the first fetch address after reset.
REQ-006 clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 mem_read_request  output  1  memory read request, held until mem_read_data_ready.
REQ-009 mem_read_addr  output  ADDR_WIDTH  address of the outstanding request.
REQ-010 mem_read_data_ready  input  1  one-cycle pulse: mem_read_data valid, request complete.
REQ-011 mem_read_data  input  WORD_WIDTH  returned instruction word.
REQ-012 redirect_valid  input  1  flush queue and restart fetch at redirect_addr.
REQ-013 redirect_addr  input  ADDR_WIDTH  new fetch address.
REQ-014 insn_valid  output  1  queue head holds an instruction.
REQ-015 insn_ready  input  1  consumer accepts head when insn_valid is high.
REQ-016 insn_data  output  WORD_WIDTH  head instruction word.
REQ-017 insn_addr  output  ADDR_WIDTH  address of the head instruction.
REQ-018 count  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-019 The block SHALL hold at most one outstanding memory request.
REQ-020 FSM states SHALL be IDLE, REQ, DROP; mem_read_request SHALL be high exactly in REQ and DROP.
REQ-021 IDLE -> REQ SHALL occur when count < DEPTH and redirect_valid is low; mem_read_addr SHALL load fetch_pc on entry to REQ.
REQ-022 mem_read_addr SHALL be stable while mem_read_request is high.
REQ-023 REQ with mem_read_data_ready and no redirect: push {mem_read_data, mem_read_addr}, fetch_pc += WORD_SIZE (mod 2^ADDR_WIDTH); stay REQ with mem_read_addr = new fetch_pc if post-update count < DEPTH, else go IDLE.
REQ-024 REQ with redirect_valid and no mem_read_data_ready: go DROP; mem_read_request and mem_read_addr SHALL stay unchanged.
REQ-025 REQ with redirect_valid and mem_read_data_ready in the same cycle: discard returned data, go IDLE.
REQ-026 DROP with mem_read_data_ready: discard data, go IDLE; a further redirect in DROP SHALL only reload fetch_pc.
REQ-027 Any redirect_valid SHALL set fetch_pc = redirect_addr, set count to 0 next cycle, and ignore insn_ready that cycle.
REQ-028 insn_valid SHALL equal (count != 0); insn_data and insn_addr SHALL show the head entry, stable until popped.
REQ-029 Pop SHALL occur when insn_valid and insn_ready are high and redirect_valid is low.
REQ-030 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-031 Push SHALL never occur when count == DEPTH (guaranteed by REQ-021/REQ-023).
REQ-032 Queue read/write pointers SHALL wrap modulo DEPTH.
REQ-033 Best-case throughput SHALL be one word per cycle when memory returns ready every cycle and the consumer pops every cycle.

Reset
REQ-034 In any cycle with reset high: state = IDLE, fetch_pc = RESET_PC, count = 0, pointers = 0, mem_read_request = 0, mem_read_addr = RESET_PC, insn_valid = 0, insn_data = 0, insn_addr = 0.
REQ-035 Reset asserted mid-request SHALL drop the request immediately; a late mem_read_data_ready SHALL be ignored.
REQ-036 The first mem_read_request SHALL assert in the second cycle after reset deasserts.

Verification (ADDR_WIDTH=32, WORD_SIZE=4, WORD_WIDTH=32, DEPTH=4, RESET_PC=0x100)
REQ-037 Reset release, memory ready one cycle after each request, insn_ready=0 -> addresses 0x100,0x104,0x108,0x10C fetched; count reaches 4; request deasserts; no fifth request.
REQ-038 Queue full, then one pop -> count 3, a new request to 0x110 issues, count returns to 4, order preserved.
REQ-039 Request to 0x104 outstanding, redirect to 0x200 with ready withheld 3 cycles -> request held at 0x104 (DROP), data dropped, next request to 0x200, count stays 0 until 0x200 returns.
REQ-040 Redirect to 0x300 in the same cycle as ready and insn_ready -> no push, no pop, count 0, next request 0x300.
REQ-041 fetch_pc = 0xFFFFFFFC, fetch completes -> next request address 0x00000000.
REQ-042 Memory ready every cycle, insn_ready=1 -> after fill, one insn per cycle at consecutive addresses, count constant.
